// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and checks them
// against build-time values. Optional periodic re-check enabled by SYSID_READER_PERIODIC_EN.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1519049163,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_READER_PERIODIC_EN
    ,
    parameter int unsigned RECHECK_PERIOD = 1000000
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
`ifdef SYSID_READER_PERIODIC_EN
    output logic        mismatch_sticky,
`endif
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
    logic        first_reg;
    logic [31:0] id_value_reg, id_value_next;
    logic [31:0] ts_value_reg, ts_value_next;
    logic        done_reg, done_next;
    logic        id_match_reg, id_match_next;
    logic        ts_match_reg, ts_match_next;
    logic        timeout_reg, timeout_next;
`ifdef SYSID_READER_PERIODIC_EN
    logic [31:0] period_cnt_reg, period_cnt_next;
    logic        sticky_reg, sticky_next;
    localparam logic [31:0] PERIOD_LAST = 32'(RECHECK_PERIOD - 1);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            tmo_cnt_reg  <= '0;
            first_reg    <= 1'b1;
            id_value_reg <= '0;
            ts_value_reg <= '0;
            done_reg     <= 1'b0;
            id_match_reg <= 1'b0;
            ts_match_reg <= 1'b0;
            timeout_reg  <= 1'b0;
`ifdef SYSID_READER_PERIODIC_EN
            period_cnt_reg <= '0;
            sticky_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            first_reg    <= 1'b0;
            id_value_reg <= id_value_next;
            ts_value_reg <= ts_value_next;
            done_reg     <= done_next;
            id_match_reg <= id_match_next;
            ts_match_reg <= ts_match_next;
            timeout_reg  <= timeout_next;
`ifdef SYSID_READER_PERIODIC_EN
            period_cnt_reg <= period_cnt_next;
            sticky_reg     <= sticky_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        id_value_next = id_value_reg;
        ts_value_next = ts_value_reg;
        done_next     = done_reg;
        id_match_next = id_match_reg;
        ts_match_next = ts_match_reg;
        timeout_next  = timeout_reg;
`ifdef SYSID_READER_PERIODIC_EN
        period_cnt_next = period_cnt_reg;
        sticky_next     = sticky_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start || (AUTO_START && first_reg)) begin
                    state_next   = RD_ID;
                    tmo_cnt_next = '0;
                end
            end
            RD_ID, RD_TS: begin
                if (!waitrequest) begin
                    tmo_cnt_next = '0;
                    if (state_reg == RD_ID) begin
                        id_value_next = readdata;
                        state_next    = RD_TS;
                    end else begin
                        ts_value_next = readdata;
                        state_next    = CHECK;
                    end
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    // Abort: the stall counter has seen TIMEOUT_CYCLES stalled cycles
                    tmo_cnt_next  = '0;
                    state_next    = DONE;
                    timeout_next  = 1'b1;
                    done_next     = 1'b1;
                    id_match_next = 1'b0;
                    ts_match_next = 1'b0;
`ifdef SYSID_READER_PERIODIC_EN
                    period_cnt_next = '0;
                    sticky_next     = 1'b1;
`endif
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                end
            end
            CHECK: begin
                id_match_next = (id_value_reg == EXPECTED_ID);
                ts_match_next = (ts_value_reg == EXPECTED_TS);
                done_next     = 1'b1;
                state_next    = DONE;
`ifdef SYSID_READER_PERIODIC_EN
                period_cnt_next = '0;
                if ((id_value_reg != EXPECTED_ID) || (ts_value_reg != EXPECTED_TS))
                    sticky_next = 1'b1;
`endif
            end
            DONE: begin
`ifdef SYSID_READER_PERIODIC_EN
                if (start || (period_cnt_reg == PERIOD_LAST)) begin
                    period_cnt_next = '0;
`else
                if (start) begin
`endif
                    state_next    = RD_ID;
                    tmo_cnt_next  = '0;
                    done_next     = 1'b0;
                    id_match_next = 1'b0;
                    ts_match_next = 1'b0;
                    timeout_next  = 1'b0;
                end
`ifdef SYSID_READER_PERIODIC_EN
                else begin
                    period_cnt_next = period_cnt_reg + 32'd1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes decode straight from state so an async reset drops them at once
    assign read     = (state_reg == RD_ID) || (state_reg == RD_TS);
    assign address  = (state_reg == RD_TS);
    assign busy     = (state_reg == RD_ID) || (state_reg == RD_TS) || (state_reg == CHECK);
    assign id_value = id_value_reg;
    assign ts_value = ts_value_reg;
    assign done     = done_reg;
    assign id_match = id_match_reg;
    assign ts_match = ts_match_reg;
    assign timeout  = timeout_reg;
`ifdef SYSID_READER_PERIODIC_EN
    assign mismatch_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader (default build): auto-start, mismatch, stall,
// timeout, ignored start while busy and asynchronous reset mid-sequence.
module tb_sysid_reader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout;

    logic [31:0] id_word;
    logic [31:0] ts_word;

    int total = 0;
    int bad   = 0;
    int accepts = 0;
    logic [1:0] acc_hist = 2'b00;
    int acc_base;

    sysid_reader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .address     (address),
        .read        (read),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .busy        (busy),
        .done        (done),
        .id_match    (id_match),
        .ts_match    (ts_match),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    // Zero-latency slave: data follows the address combinationally
    assign readdata = address ? ts_word : id_word;

    always @(posedge clock) begin
        if (read && !waitrequest) begin
            accepts  <= accepts + 1;
            acc_hist <= {acc_hist[0], address};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        waitrequest = 1'b0;
        id_word     = 32'd0;
        ts_word     = 32'd1519049163;
        repeat (2) @(posedge clock);
        #1;
        check("rst_outs", {read, address, busy, done, id_match, ts_match, timeout}, 64'd0);
        check("rst_vals", {id_value, ts_value}, 64'd0);

        // 1: auto-start after reset release, zero-wait slave
        acc_base = accepts;
        reset_n = 1'b1;
        tick();                                    // E0
        check("auto_rd_id", {read, address, busy}, 64'b101);
        tick();                                    // E1
        check("auto_rd_ts", {read, address}, 64'b11);
        tick();                                    // E2
        check("auto_check", {read, busy, done}, 64'b010);
        tick();                                    // E3
        check("auto_done", {done, id_match, ts_match, timeout, busy}, 64'b11100);
        check("auto_nacc", accepts - acc_base, 64'd2);
        check("auto_order", acc_hist, 64'b01);
        check("auto_vals", {id_value, ts_value}, {32'd0, 32'd1519049163});

        // 2: id mismatch
        id_word = 32'h0000_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mm_clr_done", {done, id_match, ts_match, read}, 64'b0001);
        repeat (3) tick();
        check("mm_idval", id_value, 64'd1);
        check("mm_flags", {done, id_match, ts_match, timeout}, 64'b1010);

        // 3: three stall cycles on the timestamp read
        id_word = 32'd0;
        start = 1'b1;
        tick();                                    // RD_ID
        start = 1'b0;
        tick();                                    // RD_TS
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {read, address, busy}, 64'b111);
        end
        waitrequest = 1'b0;
        tick();
        check("stall_cap", {read, busy, ts_value}, {32'd0, 2'b01, 32'd1519049163});
        tick();
        check("stall_done", {done, id_match, ts_match, timeout}, 64'b1110);

        // 4: waitrequest stuck high -> timeout after 16 stalled cycles
        waitrequest = 1'b1;
        start = 1'b1;
        tick();                                    // RD_ID, nothing stalled yet
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo_reading", {read, address}, 64'b10);
        end
        tick();
        check("tmo_abort", {read, busy, done, timeout, id_match, ts_match}, 64'b001100);
        waitrequest = 1'b0;
        tick();
        check("tmo_held", {read, done, timeout}, 64'b011);

        // 5: start during RD_TS is ignored; async reset mid RD_ID
        start = 1'b1;
        tick();                                    // RD_ID
        start = 1'b0;
        tick();                                    // RD_TS
        start = 1'b1;
        tick();                                    // CHECK
        start = 1'b0;
        tick();                                    // DONE
        tick();
        check("ign_start", {read, busy, done, id_match, ts_match}, 64'b00111);
        start = 1'b1;
        tick();                                    // second run, RD_ID
        start = 1'b0;
        check("run2_rd_id", {read, address}, 64'b10);
        reset_n = 1'b0;
        #1;
        check("arst_outs", {read, address, busy, done, id_match, ts_match, timeout}, 64'd0);
        check("arst_vals", {id_value, ts_value}, 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("rerun_done", {done, id_match, ts_match, timeout}, 64'b1110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
